// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run controller: FSM states, halt/reset
// addresses and the halt-condition helper.
package mips_run_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } run_state_t;

    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    // The CPU signals completion by going inactive with its PC parked on HALT_ADDR.
    function automatic logic is_halt(input logic active, input logic [31:0] instr_address);
        return !active && (instr_address == HALT_ADDR);
    endfunction

endpackage

// File: rtl/mips_run_step_gen.sv
// Per-cycle CPU clock-enable selection: forced during reset hold, free-run or
// single-step (step_req/step_ack handshake) during RUN. Outputs are registered.
module mips_run_step_gen (
    input  logic clk,
    input  logic reset,
    input  logic hold_next,
    input  logic run_next,
    input  logic step_mode,
    input  logic step_req,
    output logic step_ack,
    output logic clk_enable
);

    logic step_ack_reg, step_ack_next;
    logic clk_enable_reg, clk_enable_next;

    always_comb begin
        step_ack_next   = 1'b0;
        clk_enable_next = 1'b0;
        if (hold_next) begin
            clk_enable_next = 1'b1;
        end else if (run_next) begin
            if (!step_mode) begin
                clk_enable_next = 1'b1;
            end else if (step_req && !step_ack_reg) begin
                // A granted step blocks the following cycle, so a held
                // request produces an ack every other cycle.
                clk_enable_next = 1'b1;
                step_ack_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_ack_reg   <= 1'b0;
            clk_enable_reg <= 1'b0;
        end else begin
            step_ack_reg   <= step_ack_next;
            clk_enable_reg <= clk_enable_next;
        end
    end

    assign step_ack   = step_ack_reg;
    assign clk_enable = clk_enable_reg;

endmodule

// File: rtl/mips_run_controller.sv
// Owns CPU reset/clock-enable for one program run: timed reset, run, halt detect,
// result capture. Optional run timeout enabled by defining MIPS_RUN_TIMEOUT_EN.
module mips_run_controller
    import mips_run_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CYC_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             step_ack,
    output logic             cpu_reset,
    output logic             cpu_clk_enable,
    input  logic             cpu_active,
    input  logic [31:0]      cpu_instr_address,
    input  logic [31:0]      cpu_register_v0,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [31:0]      result,
    output logic [CYC_W-1:0] cycle_count
);

`ifdef MIPS_RUN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    run_state_t        state_reg, state_next;
    logic [RC_W-1:0]   rst_cnt_reg;
    logic [CYC_W-1:0]  cycle_count_reg, cycle_count_next;
    logic [31:0]       result_reg;
    logic              timed_out_reg;
    logic              guard_reg;
    logic              cpu_reset_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              load_rst;
    logic              enter_run;
    logic              halt_hit;
    logic              timeout_hit;

    mips_run_step_gen u_step_gen (
        .clk        (clk),
        .reset      (reset),
        .hold_next  (state_next == RESET_HOLD),
        .run_next   (state_next == RUN),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .clk_enable (cpu_clk_enable)
    );

    always_comb begin
        cycle_count_next = cycle_count_reg;
        if (state_reg == RUN && cpu_clk_enable && !(&cycle_count_reg)) begin
            cycle_count_next = cycle_count_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        load_rst    = 1'b0;
        enter_run   = 1'b0;
        halt_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RESET_HOLD;
                    load_rst   = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (rst_cnt_reg == '0) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                halt_hit = guard_reg && is_halt(cpu_active, cpu_instr_address);
                // Compare against the post-increment count so the CPU sees
                // exactly TIMEOUT_CYCLES enabled cycles; halt takes priority.
                if (halt_hit) begin
                    state_next = DONE;
                end else if (TIMEOUT_EN && (cycle_count_next == CYC_W'(TIMEOUT_CYCLES))) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RESET_HOLD;
                    load_rst   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            rst_cnt_reg     <= '0;
            cycle_count_reg <= '0;
            result_reg      <= '0;
            timed_out_reg   <= 1'b0;
            guard_reg       <= 1'b0;
            cpu_reset_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (load_rst) begin
                rst_cnt_reg <= RC_W'(RESET_CYCLES - 1);
            end else if (state_reg == RESET_HOLD && rst_cnt_reg != '0) begin
                rst_cnt_reg <= rst_cnt_reg - 1'b1;
            end

            if (enter_run) begin
                cycle_count_reg <= '0;
                result_reg      <= '0;
                timed_out_reg   <= 1'b0;
                guard_reg       <= 1'b0;
            end else if (state_reg == RUN) begin
                cycle_count_reg <= cycle_count_next;
                // Guard keeps stale pre-reset CPU outputs from looking like a halt.
                if (cpu_clk_enable) begin
                    guard_reg <= 1'b1;
                end
                if (halt_hit) begin
                    result_reg <= cpu_register_v0;
                end else if (timeout_hit) begin
                    result_reg    <= '0;
                    timed_out_reg <= 1'b1;
                end
            end

            cpu_reset_reg <= (state_next == IDLE) || (state_next == RESET_HOLD);
            busy_reg      <= (state_next == RESET_HOLD) || (state_next == RUN);
            done_reg      <= (state_next == DONE);
        end
    end

    assign cpu_reset   = cpu_reset_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timed_out   = timed_out_reg;
    assign result      = result_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller with a small behavioural CPU stand-in; expected run
// outcomes are queued at start and compared when done rises.
module tb_mips_run_controller;
    import mips_run_pkg::*;

    localparam int RC = 2;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step_req;
    logic        step_ack, cpu_reset, cpu_clk_enable;
    logic        cpu_active;
    logic [31:0] cpu_instr_address, cpu_register_v0;
    logic        busy, done, timed_out;
    logic [31:0] result, cycle_count;

    always #5 clk = ~clk;

    mips_run_controller #(
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO),
        .CYC_W          (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .step_mode         (step_mode),
        .step_req          (step_req),
        .step_ack          (step_ack),
        .cpu_reset         (cpu_reset),
        .cpu_clk_enable    (cpu_clk_enable),
        .cpu_active        (cpu_active),
        .cpu_instr_address (cpu_instr_address),
        .cpu_register_v0   (cpu_register_v0),
        .busy              (busy),
        .done              (done),
        .timed_out         (timed_out),
        .result            (result),
        .cycle_count       (cycle_count)
    );

    // CPU stand-in: first instruction sets v0, halts after halt_steps enabled cycles (0 = loop forever).
    int          halt_steps = 0;
    logic [31:0] prog_v0 = '0;
    int          steps = 0;

    initial begin
        cpu_active        = 1'b0;
        cpu_instr_address = '0;
        cpu_register_v0   = '0;
    end

    always @(posedge clk) begin
        if (cpu_clk_enable) begin
            if (cpu_reset) begin
                cpu_instr_address <= RESET_VECTOR;
                cpu_active        <= 1'b1;
                cpu_register_v0   <= '0;
                steps             <= 0;
            end else if (cpu_active) begin
                steps <= steps + 1;
                if (steps == 0) cpu_register_v0 <= prog_v0;
                if (halt_steps != 0 && steps == halt_steps - 1) begin
                    cpu_instr_address <= HALT_ADDR;
                    cpu_active        <= 1'b0;
                end else begin
                    cpu_instr_address <= cpu_instr_address + 32'd4;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] result;
        logic        timed_out;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic run_prog(input string name, input int h, input logic [31:0] v,
                            input logic [31:0] exp_count, input logic exp_to,
                            input logic [31:0] exp_res, input bit stray_start,
                            input int req_delay, output int run_cycles);
        exp_t e;
        int   acks;
        int   n;
        logic prev_ack;
        halt_steps = h;
        prog_v0    = v;
        e.result    = exp_res;
        e.timed_out = exp_to;
        e.count     = exp_count;
        sb.push_back(e);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < RC; i++) begin
            chk1("hold_cpu_reset", cpu_reset, 1'b1);
            chk1("hold_clk_enable", cpu_clk_enable, 1'b1);
            chk1("hold_busy", busy, 1'b1);
            @(negedge clk);
        end
        chk1("run_cpu_reset", cpu_reset, 1'b0);
        chk32("run_count_cleared", cycle_count, 32'd0);
        chk1("run_done_low", done, 1'b0);

        acks = 0;
        n = 0;
        prev_ack = 1'b0;
        while (!done && n < 200) begin
            if (step_ack) acks++;
            chk1("ack_not_back_to_back", prev_ack & step_ack, 1'b0);
            if (!step_mode) chk1("freerun_no_ack", step_ack, 1'b0);
            if (n < req_delay) chk1("no_req_no_enable", cpu_clk_enable, 1'b0);
            if (n == req_delay) step_req = 1'b1;
            if (stray_start && n == 2) chk1("stray_start_ignored", cpu_reset, 1'b0);
            start = (stray_start && n == 1);
            prev_ack = step_ack;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        run_cycles = n;

        chk1("done_seen", done, 1'b1);
        e = sb.pop_front();
        chk32("result", result, e.result);
        chk1("timed_out", timed_out, e.timed_out);
        chk32("cycle_count", cycle_count, e.count);
        chk1("done_busy_low", busy, 1'b0);
        chk1("done_enable_low", cpu_clk_enable, 1'b0);
        if (step_mode) chk32("acks_vs_expected_count", acks, e.count);
        $display("run %s: result=%0h timed_out=%b cycle_count=%0d run_cycles=%0d acks=%0d",
                 name, result, timed_out, cycle_count, n, acks);
    endtask

    int rc;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_cpu_reset", cpu_reset, 1'b1);
        chk1("rst_clk_enable", cpu_clk_enable, 1'b0);
        chk1("rst_step_ack", step_ack, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_timed_out", timed_out, 1'b0);
        chk32("rst_result", result, 32'd0);
        chk32("rst_cycle_count", cycle_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk1("idle_cpu_reset", cpu_reset, 1'b1);

        // Free-run with step_req held: must be ignored.
        step_req = 1'b1;
        run_prog("freerun", 3, 32'h1, 32'd4, 1'b0, 32'h1, 1'b0, 0, rc);
        chk1("done_within_10", (rc + RC + 1) <= 10, 1'b1);

        repeat (3) begin
            @(negedge clk);
            chk1("done_held", done, 1'b1);
            chk32("result_held", result, 32'h1);
            chk1("done_cpu_frozen", cpu_clk_enable, 1'b0);
            chk1("done_cpu_reset_low", cpu_reset, 1'b0);
        end

        run_prog("restart_stray_start", 5, 32'h55, 32'd6, 1'b0, 32'h55, 1'b1, 0, rc);

        step_mode = 1'b1;
        run_prog("single_step", 3, 32'h1, 32'd3, 1'b0, 32'h1, 1'b0, 0, rc);
        step_req = 1'b0;
        run_prog("single_step_late_req", 3, 32'h1, 32'd3, 1'b0, 32'h1, 1'b0, 3, rc);
        step_mode = 1'b0;
        step_req  = 1'b0;

        // Reset mid-RUN on a looping program.
        halt_steps = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RC + 4) @(negedge clk);
        chk1("midrun_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk32("midrst_cycle_count", cycle_count, 32'd0);
        chk1("midrst_cpu_reset", cpu_reset, 1'b1);
        chk1("midrst_clk_enable", cpu_clk_enable, 1'b0);
        $display("reset mid-run: busy=%b done=%b cycle_count=%0d", busy, done, cycle_count);
        @(negedge clk);
        run_prog("rerun_after_reset", 3, 32'h1, 32'd4, 1'b0, 32'h1, 1'b0, 0, rc);

`ifdef MIPS_RUN_TIMEOUT_EN
        run_prog("timeout", 0, 32'h99, 32'd20, 1'b1, 32'h0, 1'b0, 0, rc);
`endif
        // Halt observed on the same edge the count reaches TIMEOUT_CYCLES.
        run_prog("halt_at_timeout", 19, 32'h77, 32'd20, 1'b0, 32'h77, 1'b0, 0, rc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
